// File: rtl/step_run_ctrl.sv
// rtl/step_run_ctrl.sv - step/run/halt clock-enable sequencer for the core
module step_run_ctrl #(
    parameter int RUN_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_PAUSED,
        S_STEP,
        S_RUN,
        S_HALTED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             step_q;
    logic             run_q;
    logic             step_rise;
    logic             run_rise;

    assign step_rise = step_btn & ~step_q;
    assign run_rise  = run_btn & ~run_q;

    // Edge registers reset high so a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_PAUSED;
            div_cnt    <= '0;
            step_q     <= 1'b1;
            run_q      <= 1'b1;
            step_count <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            step_q  <= step_btn;
            run_q   <= run_btn;
            if (cpu_en && (step_count != {CNT_W{1'b1}})) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        if (halt_req && (state != S_HALTED)) begin
            state_nxt = S_HALTED;
            div_nxt   = '0;
        end else begin
            case (state)
                S_PAUSED: begin
                    if (run_rise) begin
                        state_nxt = S_RUN;
                        div_nxt   = '0;
                    end else if (step_rise) begin
                        state_nxt = S_STEP;
                    end
                end
                S_STEP: state_nxt = S_PAUSED;
                S_RUN: begin
                    if (run_rise) begin
                        state_nxt = S_PAUSED;
                        div_nxt   = '0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_nxt = '0;
                    end else begin
                        div_nxt = div_cnt + DIV_W'(1);
                    end
                end
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_PAUSED;
            endcase
        end
    end

    assign cpu_en  = (state == S_STEP) || ((state == S_RUN) && (div_cnt == DIV_LAST));
    assign running = (state == S_RUN);
    assign halted  = (state == S_HALTED);

endmodule

// File: tb/tb_step_run_ctrl.sv
// tb/tb_step_run_ctrl.sv - scoreboard bench for step_run_ctrl (RUN_DIV=4/CNT_W=16 and RUN_DIV=1/CNT_W=4)
module tb_step_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        step_btn = 1'b0;
    logic        run_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        en0, run0, hlt0;
    logic [15:0] cnt0;
    logic        en1, run1, hlt1;
    logic [3:0]  cnt1;

    step_run_ctrl #(.RUN_DIV(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_btn(run_btn), .halt_req(halt_req),
        .cpu_en(en0), .running(run0), .halted(hlt0), .step_count(cnt0)
    );

    step_run_ctrl #(.RUN_DIV(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_btn(run_btn), .halt_req(halt_req),
        .cpu_en(en1), .running(run1), .halted(hlt1), .step_count(cnt1)
    );

    typedef struct {
        bit en;
        bit run;
        bit hlt;
        int cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: run progress is tracked as cycles since RUN entry.
    int m_div[2] = '{4, 1};
    int m_max[2] = '{65535, 15};
    bit m_run[2], m_hlt[2], m_stp[2], m_en[2];
    int m_age[2], m_cnt[2];
    bit prev_s = 1'b1;
    bit prev_r = 1'b1;

    task automatic model_edge(input bit r, input bit s, input bit rn, input bit h);
        bit   sr, rr;
        exp_t e;
        sr = s & ~prev_s;
        rr = rn & ~prev_r;
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                m_run[i] = 0; m_hlt[i] = 0; m_stp[i] = 0; m_cnt[i] = 0; m_age[i] = 0;
            end else begin
                if (m_en[i] && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
                if (h && !m_hlt[i]) begin
                    m_hlt[i] = 1; m_run[i] = 0; m_stp[i] = 0;
                end else if (m_hlt[i]) begin
                    m_hlt[i] = 1;
                end else if (m_stp[i]) begin
                    m_stp[i] = 0;
                end else if (m_run[i]) begin
                    if (rr) m_run[i] = 0;
                    else m_age[i] = m_age[i] + 1;
                end else if (rr) begin
                    m_run[i] = 1; m_age[i] = 0;
                end else if (sr) begin
                    m_stp[i] = 1;
                end
            end
            m_en[i] = m_stp[i] || (m_run[i] && (m_age[i] % m_div[i]) == m_div[i] - 1);
            e.en = m_en[i]; e.run = m_run[i]; e.hlt = m_hlt[i]; e.cnt = m_cnt[i];
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        prev_s = r ? s : 1'b1;
        prev_r = r ? rn : 1'b1;
    endtask

    task automatic tick(input bit r, input bit s, input bit rn, input bit h);
        @(negedge clk);
        #1;
        rst = r; step_btn = s; run_btn = rn; halt_req = h;
        model_edge(r, s, rn, h);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1, 0, 0, 0);
    endtask

    task automatic cmp(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("d0_cpu_en", int'(en0), int'(e.en));
            cmp("d0_running", int'(run0), int'(e.run));
            cmp("d0_halted", int'(hlt0), int'(e.hlt));
            cmp("d0_step_count", int'(cnt0), e.cnt);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("d1_cpu_en", int'(en1), int'(e.en));
            cmp("d1_running", int'(run1), int'(e.run));
            cmp("d1_halted", int'(hlt1), int'(e.hlt));
            cmp("d1_step_count", int'(cnt1), e.cnt);
        end
    end

    initial begin
        // held step button through reset must not register
        repeat (2) tick(0, 1, 0, 0);
        repeat (10) tick(1, 1, 0, 0);
        repeat (3) tick(1, 0, 0, 0);
        repeat (5) tick(1, 1, 0, 0);
        idle(3);

        // three single steps with long holds
        for (int p = 0; p < 3; p++) begin
            repeat (20) tick(1, 1, 0, 0);
            idle(3 + $urandom_range(0, 5));
        end

        // run/pause, with step presses during RUN
        repeat (3) tick(1, 0, 1, 0);
        idle(2);
        repeat (2) tick(1, 1, 0, 0);
        idle(3);
        repeat (2) tick(1, 1, 0, 0);
        idle(1);
        tick(1, 0, 1, 0);
        idle(4);

        // simultaneous rise in PAUSED: RUN wins
        tick(1, 1, 1, 0);
        repeat (6) tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        idle(3);

        // halt from RUN, buttons ignored, then reset
        tick(1, 0, 1, 0);
        idle(5);
        tick(1, 0, 0, 1);
        for (int k = 0; k < 50; k++) tick(1, 1'($urandom), 1'($urandom), 1'($urandom));
        tick(0, 0, 0, 0);
        idle(3);

        // saturation of the narrow counter
        tick(1, 0, 1, 0);
        idle(30);
        tick(1, 0, 1, 0);
        idle(3);

        // randomized mix
        for (int k = 0; k < 2000; k++) begin
            bit s, rn, h, r;
            s  = ($urandom_range(0, 5) == 0) ? ~step_btn : step_btn;
            rn = ($urandom_range(0, 7) == 0) ? ~run_btn : run_btn;
            h  = ($urandom_range(0, 199) == 0);
            r  = ($urandom_range(0, 249) != 0);
            tick(r, s, rn, h);
        end

        idle(2);
        repeat (2) @(negedge clk);
        #2;
        cmp("queue_drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
